// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared integer ALU with a single registered result stage.
// Define ALU_ARB_PERF_EN to add saturating per-requester wait counters (perf_clr, perf_wait0, perf_wait1).
module alu_share_arbiter #(
  parameter int   OP_W      = 16,
  parameter logic FIRST_PRI = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [31:0]     req0_src1,
  input  logic [31:0]     req0_src2,
  input  logic            req0_ovf_en,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [31:0]     req1_src1,
  input  logic [31:0]     req1_src2,
  input  logic            req1_ovf_en,
`ifdef ALU_ARB_PERF_EN
  input  logic            perf_clr,
  output logic [31:0]     perf_wait0,
  output logic [31:0]     perf_wait1,
`endif
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [31:0]     resp_result,
  output logic            resp_overflow
);

  logic            resp_valid_q, resp_valid_d;
  logic            resp_id_q, resp_id_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic            resp_ovf_q, resp_ovf_d;
  logic            last_grant_q, last_grant_d;

  logic            can_accept;
  logic            grant;
  logic            accept;
  logic [OP_W-1:0] sel_op;
  logic [31:0]     sel_src1;
  logic [31:0]     sel_src2;
  logic            sel_ovf_en;
  logic            sub_like;
  logic [31:0]     b_eff;
  logic [31:0]     sum;
  logic [4:0]      shamt;
  logic [31:0]     alu_result;
  logic            alu_ovf;
  logic            unused_op_hi;

  assign can_accept = !flush && (!resp_valid_q || resp_ready);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
  end

  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_op     = grant ? req1_op     : req0_op;
  assign sel_src1   = grant ? req1_src1   : req0_src1;
  assign sel_src2   = grant ? req1_src2   : req0_src2;
  assign sel_ovf_en = grant ? req1_ovf_en : req0_ovf_en;
  assign unused_op_hi = ^sel_op[OP_W-1:12];

  // Subtract-style ops share one adder with src2 inverted and a carry-in of one.
  assign sub_like = sel_op[1] || sel_op[2] || sel_op[3];
  assign b_eff    = sub_like ? ~sel_src2 : sel_src2;
  assign sum      = sel_src1 + b_eff + {31'd0, sub_like};
  assign shamt    = sel_src1[4:0];

  always_comb begin
    alu_result = '0;
    if (sel_op[0] || sel_op[1]) alu_result = alu_result | sum;
    if (sel_op[2])  alu_result = alu_result | {31'd0, ($signed(sel_src1) < $signed(sel_src2))};
    if (sel_op[3])  alu_result = alu_result | {31'd0, (sel_src1 < sel_src2)};
    if (sel_op[4])  alu_result = alu_result | (sel_src1 & sel_src2);
    if (sel_op[5])  alu_result = alu_result | ~(sel_src1 | sel_src2);
    if (sel_op[6])  alu_result = alu_result | (sel_src1 | sel_src2);
    if (sel_op[7])  alu_result = alu_result | (sel_src1 ^ sel_src2);
    if (sel_op[8])  alu_result = alu_result | (sel_src2 << shamt);
    if (sel_op[9])  alu_result = alu_result | (sel_src2 >> shamt);
    if (sel_op[10]) alu_result = alu_result | 32'($signed(sel_src2) >>> shamt);
    if (sel_op[11]) alu_result = alu_result | {sel_src2[15:0], 16'h0000};
  end

  assign alu_ovf = sel_ovf_en && (sel_src1[31] == b_eff[31]) && (sum[31] != sel_src1[31]);

  // Flush wins over both consume and accept; an unconsumed stage simply holds.
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_ovf_d    = resp_ovf_q;
    last_grant_d  = last_grant_q;
    if (flush) begin
      resp_valid_d = 1'b0;
    end else if (accept) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = grant;
      resp_result_d = alu_result;
      resp_ovf_d    = alu_ovf;
      last_grant_d  = grant;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_ovf_q    <= 1'b0;
      last_grant_q  <= ~FIRST_PRI;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_ovf_q    <= resp_ovf_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_ovf_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] wait0_q, wait0_d;
  logic [31:0] wait1_q, wait1_d;

  // Counters stick at all-ones; a clear request beats any increment in the same cycle.
  always_comb begin
    wait0_d = wait0_q;
    wait1_d = wait1_q;
    if (perf_clr) begin
      wait0_d = '0;
      wait1_d = '0;
    end else begin
      if (req0_valid && !req0_ready && (wait0_q != 32'hFFFF_FFFF)) wait0_d = wait0_q + 32'd1;
      if (req1_valid && !req1_ready && (wait1_q != 32'hFFFF_FFFF)) wait1_d = wait1_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait0_q <= '0;
      wait1_q <= '0;
    end else begin
      wait0_q <= wait0_d;
      wait1_q <= wait1_d;
    end
  end

  assign perf_wait0 = wait0_q;
  assign perf_wait1 = wait1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, hand-written handshake
// sequences and randomized traffic checked against a cycle-level reference model.
module tb_alu_share_arbiter;

  localparam int   OP_W      = 16;
  localparam logic FIRST_PRI = 1'b0;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [OP_W-1:0] req0_op, req1_op;
  logic [31:0]     req0_src1, req0_src2, req1_src1, req1_src2;
  logic            req0_ovf_en, req1_ovf_en;
  logic            resp_valid, resp_ready, resp_id, resp_overflow;
  logic [31:0]     resp_result;
`ifdef ALU_ARB_PERF_EN
  logic            perf_clr;
  logic [31:0]     perf_wait0, perf_wait1;
`endif

  int tests = 0;
  int fails = 0;

  bit          mValid;
  bit          mId;
  logic [31:0] mResult;
  bit          mOvf;
  bit          mLast;
`ifdef ALU_ARB_PERF_EN
  longint      mWait0, mWait1;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.OP_W(OP_W), .FIRST_PRI(FIRST_PRI)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_ovf_en(req0_ovf_en),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_ovf_en(req1_ovf_en),
`ifdef ALU_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_wait0(perf_wait0), .perf_wait1(perf_wait1),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_overflow(resp_overflow)
  );

  typedef struct {
    logic [15:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic        oe;
    logic [31:0] expResult;
    logic        expOvf;
  } aluVec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference ALU from plain arithmetic; overflow via 64-bit signed range check.
  function automatic logic [32:0] refAlu(input logic [15:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic oe);
    logic [31:0] r;
    logic        o;
    longint      sa, sb, s;
    r  = 32'd0;
    o  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[0]) begin
      r = r | (a + b);
      s = sa + sb;
      if (oe && (s > MAXS || s < MINS)) o = 1'b1;
    end
    if (op[1]) begin
      r = r | (a - b);
      s = sa - sb;
      if (oe && (s > MAXS || s < MINS)) o = 1'b1;
    end
    if (op[2])  r = r | ((sa < sb) ? 32'd1 : 32'd0);
    if (op[3])  r = r | ((a < b) ? 32'd1 : 32'd0);
    if (op[4])  r = r | (a & b);
    if (op[5])  r = r | ~(a | b);
    if (op[6])  r = r | (a | b);
    if (op[7])  r = r | (a ^ b);
    if (op[8])  r = r | (b << a[4:0]);
    if (op[9])  r = r | (b >> a[4:0]);
    if (op[10]) r = r | 32'(sb >>> a[4:0]);
    if (op[11]) r = r | {b[15:0], 16'h0000};
    return {o, r};
  endfunction

  // One clock: check readies against the model, advance the model, check the response stage.
  task automatic applyStimulus();
    bit          canAcc, g, e0, e1;
    logic [32:0] ar;
    #2;
    canAcc = !flush && (!mValid || resp_ready);
    if (req0_valid && req1_valid) g = ~mLast;
    else                          g = req1_valid;
    e0 = canAcc && req0_valid && !g;
    e1 = canAcc && req1_valid && g;
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    ar = g ? refAlu(req1_op, req1_src1, req1_src2, req1_ovf_en)
           : refAlu(req0_op, req0_src1, req0_src2, req0_ovf_en);
`ifdef ALU_ARB_PERF_EN
    if (perf_clr) begin
      mWait0 = 0;
      mWait1 = 0;
    end else begin
      if (req0_valid && !e0 && mWait0 < 64'hFFFF_FFFF) mWait0++;
      if (req1_valid && !e1 && mWait1 < 64'hFFFF_FFFF) mWait1++;
    end
`endif
    @(posedge clk);
    if (flush) mValid = 1'b0;
    else if (e0 || e1) begin
      mValid  = 1'b1;
      mId     = g;
      mResult = ar[31:0];
      mOvf    = ar[32];
      mLast   = g;
    end else if (resp_ready) mValid = 1'b0;
    #1;
    checkOutput("resp_valid", {31'd0, resp_valid}, {31'd0, mValid});
    if (mValid) begin
      checkOutput("resp_id", {31'd0, resp_id}, {31'd0, mId});
      checkOutput("resp_result", resp_result, mResult);
      checkOutput("resp_overflow", {31'd0, resp_overflow}, {31'd0, mOvf});
    end
`ifdef ALU_ARB_PERF_EN
    checkOutput("perf_wait0", perf_wait0, mWait0[31:0]);
    checkOutput("perf_wait1", perf_wait1, mWait1[31:0]);
`endif
  endtask

  task automatic clearInputs();
    flush = 0; resp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_src1 = 0; req0_src2 = 0; req0_ovf_en = 0;
    req1_valid = 0; req1_op = 0; req1_src1 = 0; req1_src2 = 0; req1_ovf_en = 0;
`ifdef ALU_ARB_PERF_EN
    perf_clr = 0;
`endif
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1;
    #2;
    checkOutput("rst_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_id", {31'd0, resp_id}, 32'd0);
    checkOutput("rst_result", resp_result, 32'd0);
    checkOutput("rst_ovf", {31'd0, resp_overflow}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 0;
    mValid = 0; mId = 0; mResult = 0; mOvf = 0; mLast = ~FIRST_PRI;
`ifdef ALU_ARB_PERF_EN
    mWait0 = 0; mWait1 = 0;
`endif
  endtask

  aluVec_t vecs[$];
  logic [15:0] opPick;
  bit          savedId;
  logic [31:0] savedResult;

  initial begin
    clearInputs();
    reset = 0;
    @(posedge clk);
    #1;
    doReset();

    vecs.push_back('{16'h0001, 32'd5,          32'd3,          1'b0, 32'h0000_0008, 1'b0});
    vecs.push_back('{16'h0001, 32'h7FFF_FFFF,  32'h1,          1'b1, 32'h8000_0000, 1'b1});
    vecs.push_back('{16'h0001, 32'h7FFF_FFFF,  32'h1,          1'b0, 32'h8000_0000, 1'b0});
    vecs.push_back('{16'h0002, 32'h10,         32'h1,          1'b0, 32'h0000_000F, 1'b0});
    vecs.push_back('{16'h0002, 32'h8000_0000,  32'h1,          1'b1, 32'h7FFF_FFFF, 1'b1});
    vecs.push_back('{16'h0008, 32'h1,          32'hFFFF_FFFF,  1'b0, 32'h0000_0001, 1'b0});
    vecs.push_back('{16'h0004, 32'h1,          32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{16'h0010, 32'hF0F0,       32'hFF00,       1'b0, 32'h0000_F000, 1'b0});
    vecs.push_back('{16'h0020, 32'h0,          32'h0,          1'b0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{16'h0040, 32'hF0,         32'h0F,         1'b0, 32'h0000_00FF, 1'b0});
    vecs.push_back('{16'h0080, 32'hFF,         32'h0F,         1'b0, 32'h0000_00F0, 1'b0});
    vecs.push_back('{16'h0100, 32'd4,          32'h1,          1'b0, 32'h0000_0010, 1'b0});
    vecs.push_back('{16'h0200, 32'd4,          32'h8000_0000,  1'b0, 32'h0800_0000, 1'b0});
    vecs.push_back('{16'h0400, 32'd4,          32'h8000_0000,  1'b0, 32'hF800_0000, 1'b0});
    vecs.push_back('{16'h0800, 32'h0,          32'h1234,       1'b0, 32'h1234_0000, 1'b0});
    vecs.push_back('{16'h0000, 32'h55,         32'h66,         1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{16'hF001, 32'd2,          32'd2,          1'b0, 32'h0000_0004, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      req0_valid = 1; req0_op = vecs[i].op; req0_src1 = vecs[i].a;
      req0_src2 = vecs[i].b; req0_ovf_en = vecs[i].oe;
      applyStimulus();
      checkOutput($sformatf("vec%0d_result", i), resp_result, vecs[i].expResult);
      checkOutput($sformatf("vec%0d_ovf", i), {31'd0, resp_overflow}, {31'd0, vecs[i].expOvf});
    end
    req0_valid = 0;
    applyStimulus();

    // Tie-breaking from reset, then strict alternation.
    doReset();
    req0_valid = 1; req0_op = 16'h0002; req0_src1 = 32'h10; req0_src2 = 32'h1;
    req1_valid = 1; req1_op = 16'h0400; req1_src1 = 32'd4; req1_src2 = 32'h8000_0000;
    applyStimulus();
    checkOutput("tie1_id", {31'd0, resp_id}, 32'd0);
    checkOutput("tie1_result", resp_result, 32'h0000_000F);
    applyStimulus();
    checkOutput("tie2_id", {31'd0, resp_id}, 32'd1);
    checkOutput("tie2_result", resp_result, 32'hF800_0000);
    applyStimulus();
    checkOutput("tie3_id", {31'd0, resp_id}, 32'd0);

    // Backpressure hold with only req1 pending.
    req0_valid = 0; resp_ready = 0;
    savedId = resp_id; savedResult = resp_result;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("hold_ready1", {31'd0, req1_ready}, 32'd0);
      checkOutput("hold_result", resp_result, savedResult);
      checkOutput("hold_id", {31'd0, resp_id}, {31'd0, savedId});
    end
    resp_ready = 1;
    applyStimulus();
    checkOutput("release_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("release_id", {31'd0, resp_id}, 32'd1);

    // Flush blocks grants and leaves the round-robin pointer alone.
    req0_valid = 1; req1_valid = 1; flush = 1;
    applyStimulus();
    checkOutput("flush_valid", {31'd0, resp_valid}, 32'd0);
    flush = 0;
    applyStimulus();
    checkOutput("postflush_id", {31'd0, resp_id}, 32'd0);
    req0_valid = 0; req1_valid = 0;
    applyStimulus();

`ifdef ALU_ARB_PERF_EN
    doReset();
    req0_valid = 1; req0_op = 16'h0001;
    applyStimulus();
    req0_valid = 0; resp_ready = 0; req1_valid = 1; req1_op = 16'h0001;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("perf_wait1_five", perf_wait1, 32'd5);
    perf_clr = 1;
    applyStimulus();
    checkOutput("perf_clr", perf_wait1, 32'd0);
    perf_clr = 0; req1_valid = 0; resp_ready = 1;
    applyStimulus();
`endif

    // Randomized traffic against the model.
    doReset();
    for (int n = 0; n < 400; n++) begin
      flush      = ($urandom_range(0, 9) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARB_PERF_EN
      perf_clr   = ($urandom_range(0, 19) == 0);
`endif
      req0_valid = ($urandom_range(0, 9) < 6);
      opPick     = ($urandom_range(0, 12) == 12) ? 16'h0000 : (16'h0001 << $urandom_range(0, 11));
      req0_op    = opPick;
      req0_src1  = $urandom; req0_src2 = $urandom;
      req0_ovf_en = (opPick[0] || opPick[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
      req1_valid = ($urandom_range(0, 9) < 6);
      opPick     = ($urandom_range(0, 12) == 12) ? 16'h0000 : (16'h0001 << $urandom_range(0, 11));
      req1_op    = opPick;
      req1_src1  = $urandom; req1_src2 = $urandom;
      req1_ovf_en = (opPick[0] || opPick[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
